// File: rtl/inta_sequencer.sv
// inta_sequencer: turns a PIC INT request into the two-pulse NINTA acknowledge
// and hands the vector captured on the second pulse to the CPU via valid/ready.
module inta_sequencer #(
   parameter int PULSE_W = 2,
   parameter int GAP_W   = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       int_req,
   input  logic       if_en,
   input  logic [7:0] d_in,
   output logic       ninta,
   output logic [7:0] vec,
   output logic       vec_valid,
   input  logic       vec_ready,
   output logic       busy
);
   typedef enum logic [2:0] {IDLE, ARM, P1, GAP, P2, HOLD, COOL} state_t;
   localparam logic [3:0] PL = 4'(PULSE_W - 1);
   localparam logic [3:0] GL = 4'(GAP_W - 1);
   state_t state, state_n;
   logic s1, int_s, ninta_n, vv_n;
   logic [3:0] cnt, cnt_n;
   logic [7:0] vec_n;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1        <= 1'b0;
         int_s     <= 1'b0;
         state     <= IDLE;
         cnt       <= 4'd0;
         ninta     <= 1'b1;
         vec       <= 8'h00;
         vec_valid <= 1'b0;
      end else begin
         s1        <= int_req;
         int_s     <= s1;
         state     <= state_n;
         cnt       <= cnt_n;
         ninta     <= ninta_n;
         vec       <= vec_n;
         vec_valid <= vv_n;
      end
   end
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (int_s && if_en) state_n = ARM;
         ARM:     state_n = (int_s && if_en) ? P1 : IDLE;
         P1:      if (cnt == 4'd0) state_n = GAP;
         GAP:     if (cnt == 4'd0) state_n = P2;
         P2:      if (cnt == 4'd0) state_n = HOLD;
         HOLD:    if (vec_ready) state_n = COOL;
         COOL:    if (cnt == 4'd0) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   // ninta_n is the next value of the ninta flop, so the pin never sees a comb glitch
   always_comb begin
      cnt_n   = (cnt != 4'd0) ? cnt - 4'd1 : cnt;
      ninta_n = 1'b1;
      vec_n   = vec;
      vv_n    = vec_valid;
      unique case (state)
         ARM: begin
            ninta_n = !(int_s && if_en);
            if (int_s && if_en) cnt_n = PL;
         end
         P1: begin
            ninta_n = (cnt == 4'd0);
            if (cnt == 4'd0) cnt_n = GL;
         end
         GAP: begin
            ninta_n = (cnt != 4'd0);
            if (cnt == 4'd0) cnt_n = PL;
         end
         P2: begin
            ninta_n = (cnt == 4'd0);
            if (cnt == 4'd0) begin
               vec_n = d_in;
               vv_n  = 1'b1;
            end
         end
         HOLD: begin
            if (vec_ready) begin
               vv_n  = 1'b0;
               cnt_n = 4'd1;
            end
         end
         default: ;
      endcase
   end
   assign busy = (state != IDLE);
endmodule

// File: tb/tb_inta_sequencer.sv
// tb_inta_sequencer: scenario tasks with a vector scoreboard, on a default
// instance and a PULSE_W=1/GAP_W=3 instance.
module tb_inta_sequencer;
   logic clk = 1'b0, reset = 1'b1, int_req = 1'b0, int_req2 = 1'b0, if_en = 1'b1;
   logic vec_ready = 1'b0, vec_ready2 = 1'b0;
   logic [7:0] d_in = 8'h00;
   logic ninta, vec_valid, busy, ninta2, vec_valid2, busy2;
   logic [7:0] vec, vec2;
   int checks = 0, failures = 0;
   logic [7:0] sb[$];

   always #5 clk = ~clk;

   inta_sequencer u0 (
      .clk(clk), .reset(reset), .int_req(int_req), .if_en(if_en), .d_in(d_in),
      .ninta(ninta), .vec(vec), .vec_valid(vec_valid), .vec_ready(vec_ready), .busy(busy)
   );
   inta_sequencer #(.PULSE_W(1), .GAP_W(3)) u1 (
      .clk(clk), .reset(reset), .int_req(int_req2), .if_en(if_en), .d_in(d_in),
      .ninta(ninta2), .vec(vec2), .vec_valid(vec_valid2), .vec_ready(vec_ready2), .busy(busy2)
   );

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({ninta, vec, vec_valid, busy} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset0 got ninta=%b vec=%h vv=%b busy=%b exp 1 00 0 0", ninta, vec, vec_valid, busy);
      end
      checks++;
      if ({ninta2, vec2, vec_valid2, busy2} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset1 got ninta=%b vec=%h vv=%b busy=%b exp 1 00 0 0", ninta2, vec2, vec_valid2, busy2);
      end
      @(negedge clk) reset = 1'b0;
   endtask

   // n counts edges from the first edge that samples the request (or if_en in gate mode)
   task automatic ack(input bit sel, input int p, input int g, input logic [7:0] v, input bit gate);
      int e1, cap;
      logic en, nb, vb, bb;
      e1  = gate ? 1 : 3;
      cap = e1 + 2 * p + g;
      @(negedge clk);
      if (gate) if_en = 1'b1;
      else if (sel) int_req2 = 1'b1;
      else int_req = 1'b1;
      d_in = ~v;
      for (int n = 0; n <= cap; n++) begin
         @(posedge clk);
         #1;
         en = !((n >= e1 && n < e1 + p) || (n >= e1 + p + g && n < cap));
         nb = sel ? ninta2 : ninta;
         vb = sel ? vec_valid2 : vec_valid;
         bb = sel ? busy2 : busy;
         checks++;
         if (nb !== en) begin
            failures++;
            $display("FAIL ack_ninta dut=%0d n=%0d got %b exp %b", sel, n, nb, en);
         end
         checks++;
         if (vb !== (n >= cap)) begin
            failures++;
            $display("FAIL ack_valid dut=%0d n=%0d got %b exp %b", sel, n, vb, n >= cap);
         end
         checks++;
         if (bb !== (n >= e1 - 1)) begin
            failures++;
            $display("FAIL ack_busy dut=%0d n=%0d got %b exp %b", sel, n, bb, n >= e1 - 1);
         end
         if (n == e1 + p + g) begin
            d_in = v;
            sb.push_back(v);
         end
         if (n == e1) begin
            int_req  = 1'b0;
            int_req2 = 1'b0;
         end
      end
      d_in = 8'h00;
   endtask

   task automatic handshake(input bit sel, input int stall);
      logic [7:0] cv, exp;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL hs_scoreboard dut=%0d got empty exp entry", sel);
         return;
      end
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         checks++;
         if ((sel ? vec_valid2 : vec_valid) !== 1'b1 || (sel ? vec2 : vec) !== sb[0]) begin
            failures++;
            $display("FAIL hs_stall dut=%0d cyc=%0d got vv=%b vec=%h exp 1 %h", sel, i,
                     sel ? vec_valid2 : vec_valid, sel ? vec2 : vec, sb[0]);
         end
      end
      @(negedge clk);
      if (sel) vec_ready2 = 1'b1; else vec_ready = 1'b1;
      cv = sel ? vec2 : vec;
      checks++;
      if ((sel ? vec_valid2 : vec_valid) !== 1'b1) begin
         failures++;
         $display("FAIL hs_valid dut=%0d got 0 exp 1", sel);
      end
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      vec_ready  = 1'b0;
      vec_ready2 = 1'b0;
      checks++;
      if (cv !== exp) begin
         failures++;
         $display("FAIL hs_vec dut=%0d got %h exp %h", sel, cv, exp);
      end
      checks++;
      if ((sel ? vec_valid2 : vec_valid) !== 1'b0 || (sel ? vec2 : vec) !== exp) begin
         failures++;
         $display("FAIL hs_accept dut=%0d got vv=%b vec=%h exp 0 %h", sel,
                  sel ? vec_valid2 : vec_valid, sel ? vec2 : vec, exp);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ((sel ? busy2 : busy) !== (i < 2)) begin
            failures++;
            $display("FAIL hs_cool dut=%0d cyc=%0d got busy=%b exp %b", sel, i, sel ? busy2 : busy, i < 2);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_basic();
      ack(1'b0, 2, 2, 8'h4A, 1'b0);
   endtask

   task automatic test_stall();
      handshake(1'b0, 5);
   endtask

   task automatic test_if_en();
      @(negedge clk);
      if_en   = 1'b0;
      int_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (ninta !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL gated cyc=%0d got ninta=%b busy=%b exp 1 0", i, ninta, busy);
         end
      end
      ack(1'b0, 2, 2, 8'hC3, 1'b1);
      handshake(1'b0, 0);
   endtask

   task automatic test_withdraw();
      @(negedge clk) int_req = 1'b1;
      @(negedge clk) int_req = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         @(posedge clk);
         #1;
         checks++;
         if (ninta !== 1'b1 || vec_valid !== 1'b0 || busy !== (n == 2)) begin
            failures++;
            $display("FAIL withdraw n=%0d got ninta=%b vv=%b busy=%b exp 1 0 %b", n, ninta, vec_valid, busy, n == 2);
         end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk) int_req = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      checks++;
      if (ninta !== 1'b0) begin
         failures++;
         $display("FAIL mid_p2 got ninta=%b exp 0", ninta);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({ninta, vec, vec_valid, busy} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL mid_reset got ninta=%b vec=%h vv=%b busy=%b exp 1 00 0 0", ninta, vec, vec_valid, busy);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      ack(1'b0, 2, 2, 8'h5A, 1'b0);
      handshake(1'b0, 2);
   endtask

   task automatic test_sweep();
      ack(1'b1, 1, 3, 8'hFF, 1'b0);
      handshake(1'b1, 1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_if_en();
      test_withdraw();
      test_reset_mid();
      test_sweep();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_left got %0d exp 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
